jtag_tap_multi: RTL

Parametrised IEEE 1149.1 test-access-port controller with a configurable instruction width and a configurable number of user data-register channels, plus mandatory BYPASS and IDCODE registers. It is the DUT-side counterpart of the jtag_agent_a/jtag_agent_b bench interfaces, which drive and observe its TAP pins. It generalises the single-chain TAP to NUM_DR independently addressable channels, each with its own capture input, update output and update strobe.

---
 rtl/jtag_tap_pkg.sv | 39 +++
 rtl/jtag_tap_fsm.sv | 46 ++++
 rtl/jtag_tap_multi.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: 1149.1 state encodings and opcode decode helpers.
package jtag_tap_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SHIFT_DR = 4'h2,
        EXIT1_DR = 4'h1,
        PAUSE_DR = 4'h3,
        EXIT2_DR = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SHIFT_IR = 4'hA,
        EXIT1_IR = 4'h9,
        PAUSE_IR = 4'hB,
        EXIT2_IR = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_e;

    localparam logic [31:0] OPC_IDCODE = 32'd1;
    localparam int          CHAN_BASE  = 2;

    function automatic logic is_channel(input logic [31:0] op, input int num_dr);
        return (op >= CHAN_BASE) && (op < CHAN_BASE + num_dr);
    endfunction

    // Anything that is neither IDCODE nor a live channel falls back to BYPASS.
    function automatic logic is_bypass(input logic [31:0] op, input int num_dr);
        return (op != OPC_IDCODE) && !is_channel(op, num_dr);
    endfunction

    function automatic int chan_index(input logic [31:0] op);
        return int'(op) - CHAN_BASE;
    endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller: state register and tms-driven next-state logic only.
module jtag_tap_fsm
    import jtag_tap_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst_n,
    input  logic       i_tms,
    output tap_state_e o_state,
    output tap_state_e o_state_next
);

    tap_state_e r_state;
    tap_state_e w_next;

    always_ff @(posedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) r_state <= TLR;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = TLR;
        unique case (r_state)
            TLR:      w_next = i_tms ? TLR      : RTI;
            RTI:      w_next = i_tms ? SEL_DR   : RTI;
            SEL_DR:   w_next = i_tms ? SEL_IR   : CAP_DR;
            CAP_DR:   w_next = i_tms ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: w_next = i_tms ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: w_next = i_tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: w_next = i_tms ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: w_next = i_tms ? UPD_DR   : SHIFT_DR;
            UPD_DR:   w_next = i_tms ? SEL_DR   : RTI;
            SEL_IR:   w_next = i_tms ? TLR      : CAP_IR;
            CAP_IR:   w_next = i_tms ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: w_next = i_tms ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: w_next = i_tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: w_next = i_tms ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: w_next = i_tms ? UPD_IR   : SHIFT_IR;
            UPD_IR:   w_next = i_tms ? SEL_DR   : RTI;
            default:  w_next = TLR;
        endcase
    end

    assign o_state      = r_state;
    assign o_state_next = w_next;

endmodule

// File: rtl/jtag_tap_multi.sv
// TAP with IR, BYPASS, IDCODE and NUM_DR user channels sharing one DR shift register.
module jtag_tap_multi
    import jtag_tap_pkg::*;
#(
    parameter int          IR_WIDTH   = 4,
    parameter int          NUM_DR     = 2,
    parameter int          DR_WIDTH   = 8,
    parameter logic [31:0] IDCODE_VAL = 32'h1234_5001
) (
    input  logic                         tck,
    input  logic                         trst_n,
    input  logic                         tms,
    input  logic                         tdi,
    output logic                         tdo,
    output logic                         tdo_en,
    input  logic [NUM_DR*DR_WIDTH-1:0]   dr_capture_i,
    output logic [NUM_DR*DR_WIDTH-1:0]   dr_update_o,
    output logic [NUM_DR-1:0]            dr_update_strb_o,
    output logic [IR_WIDTH-1:0]          ir_o,
    output logic [3:0]                   tap_state_o
);

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);

    tap_state_e          w_state;
    tap_state_e          w_state_next;
    logic [IR_WIDTH-1:0] r_ir;
    logic [IR_WIDTH-1:0] r_ir_sr;
    logic [31:0]         r_dr_sr;
    logic                r_tdo;
    logic                r_tdo_en;
    logic [31:0]         w_op;
    logic                w_is_chan;
    int                  w_chan;
    logic [DR_WIDTH-1:0] w_chan_cap;
    logic [31:0]         w_dr_cap;
    logic [4:0]          w_dr_msb;
    logic [31:0]         w_dr_shifted;

    jtag_tap_fsm u_fsm (
        .i_tck        (tck),
        .i_trst_n     (trst_n),
        .i_tms        (tms),
        .o_state      (w_state),
        .o_state_next (w_state_next)
    );

    assign w_op      = 32'(r_ir);
    assign w_is_chan = is_channel(w_op, NUM_DR);
    assign w_chan    = chan_index(w_op);

    always_comb begin
        w_chan_cap = '0;
        for (int k = 0; k < NUM_DR; k++) begin
            if (w_is_chan && (w_chan == k)) w_chan_cap = dr_capture_i[k*DR_WIDTH +: DR_WIDTH];
        end
    end

    // Selected register's capture value and MSB position, where tdi enters during shift.
    always_comb begin
        w_dr_cap = '0;
        w_dr_msb = 5'd0;
        if (is_bypass(w_op, NUM_DR)) begin
            w_dr_cap = '0;
            w_dr_msb = 5'd0;
        end else if (w_op == OPC_IDCODE) begin
            w_dr_cap = IDCODE_VAL;
            w_dr_msb = 5'd31;
        end else begin
            w_dr_cap[DR_WIDTH-1:0] = w_chan_cap;
            w_dr_msb = 5'(DR_WIDTH - 1);
        end
    end

    always_comb begin
        w_dr_shifted           = r_dr_sr >> 1;
        w_dr_shifted[w_dr_msb] = tdi;
    end

    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_ir    <= IR_IDCODE;
            r_ir_sr <= '0;
            r_dr_sr <= '0;
        end else begin
            case (w_state)
                CAP_IR:   r_ir_sr <= IR_CAPTURE;
                SHIFT_IR: r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
                CAP_DR:   r_dr_sr <= w_dr_cap;
                SHIFT_DR: r_dr_sr <= w_dr_shifted;
                default:  ;
            endcase
            // Forcing on the next state keeps ir_o at IDCODE for the whole TLR stay.
            if (w_state_next == TLR)  r_ir <= IR_IDCODE;
            else if (w_state == UPD_IR) r_ir <= r_ir_sr;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DR; gi++) begin : g_chan
            logic [DR_WIDTH-1:0] r_upd;
            logic                r_strb;
            logic                w_hit;

            assign w_hit = (w_state == UPD_DR) && w_is_chan && (w_chan == gi);

            always_ff @(posedge tck or negedge trst_n) begin
                if (!trst_n) begin
                    r_upd  <= '0;
                    r_strb <= 1'b0;
                end else begin
                    r_strb <= w_hit;
                    if (w_hit) r_upd <= r_dr_sr[DR_WIDTH-1:0];
                end
            end

            assign dr_update_o[gi*DR_WIDTH +: DR_WIDTH] = r_upd;
            assign dr_update_strb_o[gi]                 = r_strb;
        end
    endgenerate

    always_ff @(negedge tck or negedge trst_n) begin
        if (!trst_n) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo_en <= (w_state == SHIFT_DR) || (w_state == SHIFT_IR);
            r_tdo    <= (w_state == SHIFT_DR) ? r_dr_sr[0] :
                        (w_state == SHIFT_IR) ? r_ir_sr[0] : 1'b0;
        end
    end

    assign tdo         = r_tdo;
    assign tdo_en      = r_tdo_en;
    assign ir_o        = r_ir;
    assign tap_state_o = w_state;

endmodule
